sipo_deser: RTL and testbench
=============================

# sipo_deser

Parametrised serial-in/parallel-out deserializer, the next generation of the 8-bit SIPO shift register. It adds configurable width, build-time bit order, a frame bit counter, a holding register with valid/ready output handshake, frame resync, and sticky overrun detection. It sits between a bit-serial source, gated by `en`, and a word-wide consumer that may apply backpressure.

## Interface
- `WIDTH`, default 8: word width in bits; legal values are ≥ 2.
- `DIR`, default `LSB_FIRST`: bit order, of type `sipo_pkg::shift_dir_e`.
  - `LSB_FIRST`: first received bit lands in `sipo_out[0]`.
  - `MSB_FIRST`: first received bit lands in `sipo_out[WIDTH-1]`.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `en` input 1: bit strobe; `sipo_in` is sampled on edges where `en` = 1.
- `sipo_in` input 1: serial data bit.
- `clr` input 1: synchronous frame resync.
- `out_ready` input 1: consumer ready.
- `sipo_out` output WIDTH: holding register carrying the last completed word.
- `out_valid` output 1: `sipo_out` holds an unconsumed word.
- `overrun` output 1: sticky flag; a completed word was dropped.
- `bit_cnt` output `$clog2(WIDTH)`: bits received in the current frame, range 0..WIDTH-1.

## Operation
- **Shift register `sr`** (internal, WIDTH bits).
  - `LSB_FIRST`: `sr <= {sipo_in, sr[WIDTH-1:1]}`.
  - `MSB_FIRST`: `sr <= {sr[WIDTH-2:0], sipo_in}`.
  - `sr` shifts only when `en` = 1 and `clr` = 0.
- **Bit counter.**
  - Increments on each accepted bit.
  - Wraps from WIDTH-1 to 0 on the edge that accepts the last bit of a frame. That edge is the "word complete" event.
- **Word complete.** The assembled word is `sr` shifted with the current `sipo_in`.
  - Load case: if the holding register is free (`out_valid` = 0, or `out_valid && out_ready` on this edge), load `sipo_out` with the word and set `out_valid` = 1.
  - Drop case: otherwise, drop the new word, leave `sipo_out` unchanged and set `overrun` = 1.
- **Handshake.** A transfer happens on an edge where `out_valid && out_ready`.
  - After a transfer, `out_valid` clears unless a word completes on the same edge; in that case it stays 1 with the new data.
  - `sipo_out` holds its value while `out_valid` = 1 and no transfer occurs.
- **`clr`.**
  - Clears `sr`, `bit_cnt` and `overrun`.
  - Discards any `en`/`sipo_in` on the same edge; `clr` has priority.
  - Does not affect `sipo_out` or `out_valid`; a pending word can still be consumed.
- **`rst`.** Has priority over everything. On reset `sr`, `sipo_out`, `out_valid`, `overrun` and `bit_cnt` all become 0.
- **Reset mid-frame.** Partial bits are lost, and the next accepted bit is bit 0 of a new frame.

## Timing
- `en` may be held high continuously, giving one bit per clock, or gapped arbitrarily. Gaps do not disturb the frame.
- Latency: `out_valid` and `sipo_out` update on the same edge that samples the WIDTH-th bit, so they are visible in the following cycle.
- Throughput: one word per WIDTH accepted bits. No bubble is needed between frames.
- `out_ready` may be asserted before `out_valid`; no combinational path from `out_ready` to any output.
- `overrun` sets on the drop edge and stays set until `clr` or `rst`.

## Structure
- Package `sipo_pkg`:
  - `typedef enum logic {LSB_FIRST, MSB_FIRST} shift_dir_e`.
  - `localparam int SIPO_DEFAULT_WIDTH = 8`.
- Sub-module `sipo_bit_cnt`:
  - Parameter `WIDTH`; ports `clk`, `rst`, `clr`, `inc`, `cnt`, `last`.
  - `last` = (`cnt` == WIDTH-1) && `inc`.
  - Instantiated once.
- Top level holds the shift register, the holding register, handshake and overrun logic.

## Test plan
All scenarios use `WIDTH` = 8.
- Reset: `rst` = 1 for 2 cycles with random inputs -> `sipo_out` = 0x00, `out_valid` = 0, `overrun` = 0, `bit_cnt` = 0.
- `LSB_FIRST`, continuous `en`, `out_ready` = 1, stream 1,0,1,1,1,0,0,0 -> `out_valid` high for exactly 1 cycle, `sipo_out` = 0x1D.
- `MSB_FIRST`, same stream -> `sipo_out` = 0xB8.
- Backpressure, `LSB_FIRST`, `out_ready` = 0, send words 0x1D then 0xFF:
  - `sipo_out` stays 0x1D, `out_valid` stays 1, `overrun` rises on the 16th bit edge.
  - `out_ready` = 1 for 1 cycle -> `out_valid` = 0, `overrun` stays 1.
  - `clr` -> `overrun` = 0.
- Gapped `en` (every 3rd cycle):
  - Send 3 bits, pulse `clr`, then send word 0x5A -> `bit_cnt` = 0 after `clr`, `sipo_out` = 0x5A, no overrun.
  - Repeat with `rst` instead of `clr` mid-frame -> same result.
- Simultaneous event: `out_valid` = 1 with 0x1D pending, `out_ready` = 1 on the edge completing 0xA3 -> `sipo_out` = 0xA3, `out_valid` stays 1, `overrun` = 0.

Source files
------------

// File: rtl/sipo_deser_pkg.sv
// Shared types and defaults for the serial-in/parallel-out deserializer.
package sipo_pkg;

    typedef enum logic {LSB_FIRST, MSB_FIRST} shift_dir_e;

    localparam int SIPO_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sipo_deser_if.sv
// Bit-serial input plus word-wide valid/ready output bundle.
interface sipo_deser_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) ();
    localparam int CW = $clog2(WIDTH);

    logic             en;
    logic             sipo_in;
    logic             clr;
    logic             out_ready;
    logic [WIDTH-1:0] sipo_out;
    logic             out_valid;
    logic             overrun;
    logic [CW-1:0]    bit_cnt;

    modport master (
        output en, sipo_in, clr, out_ready,
        input  sipo_out, out_valid, overrun, bit_cnt
    );

    modport slave (
        input  en, sipo_in, clr, out_ready,
        output sipo_out, out_valid, overrun, bit_cnt
    );
endinterface

// File: rtl/sipo_deser_bit_cnt.sv
// Frame bit counter; last flags the edge accepting the final bit.
module sipo_bit_cnt #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last
);
    assign last = inc && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (last) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/sipo_deser.sv
// Parametrised deserializer: shift register, holding register, handshake.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int         WIDTH = SIPO_DEFAULT_WIDTH,
    parameter shift_dir_e DIR   = LSB_FIRST
) (
    input logic        clk,
    input logic        rst,
    sipo_deser_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] hold;
    logic             valid;
    logic             ovr;
    logic [CW-1:0]    cnt;
    logic             inc;
    logic             last;
    logic             xfer;
    logic             free;

    assign inc  = bus.en && !bus.clr;
    assign xfer = valid && bus.out_ready;
    assign free = !valid || bus.out_ready;

    always_comb begin
        word = sr;
        if (DIR == LSB_FIRST) begin
            word = {bus.sipo_in, sr[WIDTH-1:1]};
        end else begin
            word = {sr[WIDTH-2:0], bus.sipo_in};
        end
    end

    sipo_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.clr),
        .inc  (inc),
        .cnt  (cnt),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            hold  <= '0;
            valid <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            if (bus.clr) begin
                sr <= '0;
            end else if (bus.en) begin
                sr <= word;
            end

            if (bus.clr) begin
                ovr <= 1'b0;
            end else if (last && !free) begin
                ovr <= 1'b1;
            end

            // A completing word may refill the slot on the same edge it drains.
            if (last && free) begin
                hold  <= word;
                valid <= 1'b1;
            end else if (xfer) begin
                valid <= 1'b0;
            end
        end
    end

    assign bus.sipo_out  = hold;
    assign bus.out_valid = valid;
    assign bus.overrun   = ovr;
    assign bus.bit_cnt   = cnt;
endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser, LSB- and MSB-first instances side by side.
module tb_sipo_deser;
    import sipo_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic sipo_in;
    logic clr;
    logic out_ready;

    int n_cmp = 0;
    int n_err = 0;

    sipo_deser_if #(.WIDTH(8)) lsb_if ();
    sipo_deser_if #(.WIDTH(8)) msb_if ();

    assign lsb_if.en        = en;
    assign lsb_if.sipo_in   = sipo_in;
    assign lsb_if.clr       = clr;
    assign lsb_if.out_ready = out_ready;
    assign msb_if.en        = en;
    assign msb_if.sipo_in   = sipo_in;
    assign msb_if.clr       = clr;
    assign msb_if.out_ready = out_ready;

    sipo_deser #(.WIDTH(8), .DIR(LSB_FIRST)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (lsb_if.slave)
    );

    sipo_deser #(.WIDTH(8), .DIR(MSB_FIRST)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (msb_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        en      = 1'b1;
        sipo_in = b;
        tick();
    endtask

    task automatic gap_bit(input logic b);
        send_bit(b);
        en = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] w;

    initial begin
        rst       = 1'b1;
        en        = 1'($urandom);
        sipo_in   = 1'($urandom);
        clr       = 1'($urandom);
        out_ready = 1'($urandom);
        tick();
        en        = 1'($urandom);
        sipo_in   = 1'($urandom);
        tick();
        chk("rst_out", 32'(lsb_if.sipo_out), 32'h00);
        chk("rst_valid", 32'(lsb_if.out_valid), 32'h0);
        chk("rst_ovr", 32'(lsb_if.overrun), 32'h0);
        chk("rst_cnt", 32'(lsb_if.bit_cnt), 32'h0);
        rst       = 1'b0;
        en        = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b1;
        tick();

        w = 8'h1D;
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        chk("s1_pre_valid", 32'(lsb_if.out_valid), 32'h0);
        chk("s1_cnt7", 32'(lsb_if.bit_cnt), 32'h7);
        send_bit(w[7]);
        en = 1'b0;
        chk("s1_valid", 32'(lsb_if.out_valid), 32'h1);
        chk("s1_lsb", 32'(lsb_if.sipo_out), 32'h1D);
        chk("s1_msb", 32'(msb_if.sipo_out), 32'hB8);
        chk("s1_wrap", 32'(lsb_if.bit_cnt), 32'h0);
        tick();
        chk("s1_post_valid", 32'(lsb_if.out_valid), 32'h0);
        chk("s1_msb_valid", 32'(msb_if.out_valid), 32'h0);

        do_reset();
        out_ready = 1'b0;
        w = 8'h1D;
        for (int i = 0; i < 8; i++) send_bit(w[i]);
        chk("bp_out1", 32'(lsb_if.sipo_out), 32'h1D);
        w = 8'hFF;
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        chk("bp_ovr15", 32'(lsb_if.overrun), 32'h0);
        send_bit(w[7]);
        en = 1'b0;
        chk("bp_ovr16", 32'(lsb_if.overrun), 32'h1);
        chk("bp_hold", 32'(lsb_if.sipo_out), 32'h1D);
        chk("bp_valid", 32'(lsb_if.out_valid), 32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_drain", 32'(lsb_if.out_valid), 32'h0);
        chk("bp_ovr_sticky", 32'(lsb_if.overrun), 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("bp_clr_ovr", 32'(lsb_if.overrun), 32'h0);

        gap_bit(1'b1);
        gap_bit(1'b1);
        gap_bit(1'b0);
        chk("gc_cnt3", 32'(lsb_if.bit_cnt), 32'h3);
        clr     = 1'b1;
        en      = 1'b1;
        sipo_in = 1'b1;
        tick();
        clr = 1'b0;
        en  = 1'b0;
        chk("gc_clr_cnt", 32'(lsb_if.bit_cnt), 32'h0);
        w = 8'h5A;
        for (int i = 0; i < 8; i++) gap_bit(w[i]);
        chk("gc_out", 32'(lsb_if.sipo_out), 32'h5A);
        chk("gc_valid", 32'(lsb_if.out_valid), 32'h1);
        chk("gc_ovr", 32'(lsb_if.overrun), 32'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        gap_bit(1'b0);
        gap_bit(1'b1);
        gap_bit(1'b1);
        do_reset();
        chk("gr_cnt", 32'(lsb_if.bit_cnt), 32'h0);
        chk("gr_out", 32'(lsb_if.sipo_out), 32'h00);
        for (int i = 0; i < 8; i++) gap_bit(w[i]);
        chk("gr_word", 32'(lsb_if.sipo_out), 32'h5A);
        chk("gr_valid", 32'(lsb_if.out_valid), 32'h1);
        chk("gr_ovr", 32'(lsb_if.overrun), 32'h0);

        do_reset();
        out_ready = 1'b0;
        w = 8'h1D;
        for (int i = 0; i < 8; i++) send_bit(w[i]);
        chk("sim_pend", 32'(lsb_if.sipo_out), 32'h1D);
        w = 8'hA3;
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        out_ready = 1'b1;
        send_bit(w[7]);
        en = 1'b0;
        chk("sim_out", 32'(lsb_if.sipo_out), 32'hA3);
        chk("sim_valid", 32'(lsb_if.out_valid), 32'h1);
        chk("sim_ovr", 32'(lsb_if.overrun), 32'h0);
        tick();
        chk("sim_drain", 32'(lsb_if.out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
